// File: rtl/r8_mbe_seq_mult_pkg.sv
// Shared types and constants for the iterative radix-8 Booth multiplier.
package r8_mbe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } mult_state_t;

   // Bit positions inside the booth_encoder output word.
   localparam int SEL_1X  = 0;
   localparam int SEL_2X  = 1;
   localparam int SEL_3X  = 2;
   localparam int SEL_4X  = 3;
   localparam int SEL_NEG = 4;

   function automatic int num_digits(input int n);
      return (n + 2) / 3;
   endfunction

endpackage

// File: rtl/r8_mbe_seq_mult_if.sv
// Operand/product handshake bundle between producer, multiplier and consumer.
interface r8_mbe_seq_mult_if #(parameter int N = 16);

   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] p;
   logic           busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, busy
   );

endinterface

// File: rtl/r8_mbe_seq_mult_booth_encoder.sv
// Radix-8 Booth recoder: 4-bit overlapping group to one-hot magnitude plus sign.
// Purely combinational; group 1111 yields sign=1 with all magnitude bits clear.
module booth_encoder
   import r8_mbe_pkg::*;
(
   input  logic [3:0] grp_i,
   output logic [4:0] be_o
);

   always_comb begin
      be_o          = '0;
      be_o[SEL_NEG] = grp_i[3];
      case (grp_i)
         4'b0001, 4'b0010, 4'b1101, 4'b1110: be_o[SEL_1X] = 1'b1;
         4'b0011, 4'b0100, 4'b1011, 4'b1100: be_o[SEL_2X] = 1'b1;
         4'b0101, 4'b0110, 4'b1001, 4'b1010: be_o[SEL_3X] = 1'b1;
         4'b0111, 4'b1000:                   be_o[SEL_4X] = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/r8_mbe_seq_mult.sv
// Iterative signed NxN radix-8 Booth multiplier, one digit per clock after a 3X pre-compute cycle.
// Product valid D+1 edges after accept; holds in DONE until out_ready, with same-cycle re-accept.
module r8_mbe_seq_mult
   import r8_mbe_pkg::*;
#(
   parameter int N = 16
)
(
   input  logic              clk,
   input  logic              rst,
   r8_mbe_seq_mult_if.slave  bus
);

   localparam int             D    = num_digits(N);
   localparam int             CW   = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0]  LAST = CW'(D - 1);

   mult_state_t     state_q, state_d;
   logic [N-1:0]    x_q, x_d;
   logic [N+1:0]    x3_q, x3_d;
   logic [N:0]      y_q, y_d;      // {B, B[-1]}; low 4 bits are the current group
   logic [2*N-1:0]  acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [4:0]      be;
   logic [2*N-1:0]  x_ext, mag, term, term_sh;
   logic            load;
   logic            in_ready, out_valid, busy;

   booth_encoder u_enc (
      .grp_i (y_q[3:0]),
      .be_o  (be)
   );

   always_comb begin
      x_ext = {{N{x_q[N-1]}}, x_q};
      mag   = '0;
      if (be[SEL_1X])      mag = x_ext;
      else if (be[SEL_2X]) mag = x_ext << 1;
      else if (be[SEL_3X]) mag = {{(N-2){x3_q[N+1]}}, x3_q};
      else if (be[SEL_4X]) mag = x_ext << 2;
      term    = be[SEL_NEG] ? -mag : mag;
      term_sh = term << (3 * cnt_q);
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      x3_d      = x3_q;
      y_d       = y_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            load     = bus.in_valid;
         end
         PRE: begin
            busy    = 1'b1;
            x3_d    = {x_q[N-1], x_q[N-1], x_q} + {x_q[N-1], x_q, 1'b0};
            state_d = ITER;
         end
         ITER: begin
            busy  = 1'b1;
            acc_d = acc_q + term_sh;
            y_d   = {{3{y_q[N]}}, y_q[N:3]};
            if (cnt_q == LAST) state_d = DONE;
            else               cnt_d   = cnt_q + 1'b1;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               in_ready = 1'b1;
               load     = bus.in_valid;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         x_d     = bus.a;
         y_d     = {bus.b, 1'b0};
         acc_d   = '0;
         cnt_d   = '0;
         state_d = PRE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         x3_q    <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         x3_q    <= x3_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.p         = acc_q;

endmodule

// File: doc/r8_mbe_seq_mult.md
# r8_mbe_seq_mult

Iterative signed N×N radix-8 Modified-Booth multiplier. It retires one Booth digit (3 multiplier bits) per clock through a single `booth_encoder` instance and one partial-product accumulator. It sits beside the parallel Dadda-tree multiplier as the low-area option and is fed by a valid/ready producer. A separate pre-compute cycle builds the hard multiple 3X, so only one adder is needed per iteration.

## Interface
- `N`, default 16: operand width, signed two's complement, N ≥ 4.
- `D`, derived localparam ceil(N/3): number of Booth digits (6 for N=16).
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands valid.
- `in_ready`, output, 1: block can accept operands.
- `a`, input, N: multiplicand X, signed.
- `b`, input, N: multiplier Y, signed.
- `out_valid`, output, 1: product valid.
- `out_ready`, input, 1: consumer accepts product.
- `p`, output, 2N: signed product a·b.
- `busy`, output, 1: high in PRE or ITER.

## Operation
- States are IDLE, PRE, ITER and DONE.
- **IDLE:** `in_ready`=1. On `in_valid`&&`in_ready`, latch `a` and `b`, clear the accumulator and digit counter, then go to PRE.
- **PRE:** compute 3X = X + 2X, sign-extended to N+2 bits, and register it. Go to ITER.
- **ITER:** digit i = 0..D-1 uses the group {B[3i+2], B[3i+1], B[3i], B[3i-1]}.
  - B[-1] = 0.
  - B[j] = B[N-1] for j ≥ N.
  - The group drives `booth_encoder`:
    - BE_out[0] = |d|=1, BE_out[1] = |d|=2, BE_out[2] = |d|=3, BE_out[3] = |d|=4. These four bits are one-hot or all zero.
    - BE_out[4] = sign.
  - Magnitude mux selects X, 2X, 3X, 4X or 0.
  - If sign=1, negate in 2N-bit two's complement. Group 1111 gives sign=1 with magnitude 0, so the term must be exactly 0.
  - acc ← acc + (term << 3i), all mod 2^(2N).
  - After digit D-1, go to DONE.
- **DONE:** `out_valid`=1 and `p`=acc. `p` and `out_valid` hold stable until `out_ready`=1.
  - On `out_valid`&&`out_ready`: if `in_valid`=1, accept the new operands in the same cycle and go to PRE. Otherwise go to IDLE.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). It is combinational from `out_ready`. This is the only combinational in→out path.
- `a` and `b` are ignored outside an accepting handshake. Changing them mid-operation has no effect.
- **Reset:** synchronous `rst` at any state, including mid-ITER or DONE with a pending product. Next cycle: state=IDLE, `out_valid`=0, `busy`=0, `in_ready`=1, `p`=0, acc=0. The in-flight product is discarded and never presented.

## Timing
- Accepting edge E0. State is PRE for the cycle after E0, then ITER for D cycles. `out_valid` rises after edge E0+D+1 (7 edges for N=16).
- Throughput is one product per D+2 cycles with back-to-back handshakes in DONE, and D+3 cycles via IDLE.
- `p` is registered and is a direct copy of acc.
- Reset values of every output:
  - `out_valid` = 0
  - `busy` = 0
  - `in_ready` = 1
  - `p` = 0
- Digit counter width is clog2(D). It saturates at D-1 and never wraps.

## Structure
- Shared package `r8_mbe_pkg` holds:
  - the state enum `mult_state_t` (IDLE, PRE, ITER, DONE);
  - the function `num_digits(N)` = (N+2)/3;
  - the BE_out bit-index constants SEL_1X, SEL_2X, SEL_3X, SEL_4X and SEL_NEG (0..4).
- One sub-module, `booth_encoder`, is instantiated once and reused. The 4-bit group comes from a multiplier shift register that shifts right by 3 each ITER cycle with sign extension, keeping the previous MSB as B[3i-1].
- The multiple mux and the accumulator adder stay inline.

## Test plan
- a=7, b=3: the single 3X digit (group 0110) is used; `p`=21, with `out_valid` on the 7th edge after accept.
- a=12345, b=-3: `p`=0xFFFF6F55 (-37035), which exercises the negative digits and sign extension.
- a=-32768, b=-32768: `p`=0x40000000. a=-1, b=-1: `p`=1, which exercises the 1111 group giving zero.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`. `p` and `out_valid` stay stable and `in_ready`=0. Then assert `out_ready` and `in_valid` together: the new operands are accepted in the same cycle, the next product follows D+2 cycles later, and there are no bubbles or duplicates.
- Assert `rst` in ITER digit 3. Next cycle all outputs are at their reset values; no stale `out_valid` appears. A fresh 100×-100 then gives `p`=0xFFFFD8F0.
- Random signed operands, 10k vectors including ±max/min, with a scoreboard checking `p` == a*b.
